// File: rtl/ewrapper_rx_deser_align.sv
// rtl/ewrapper_rx_deser_align.sv - eLink receive deserializer with bitslip word alignment
// Per-lane DDR pair shifter, RATIO-bit capture through a slip offset, and a frame-lane training hunt.
module ewrapper_rx_deser_align #(
  parameter int NCH = 9,
  parameter int RATIO = 8,
  parameter int FRAME_LANE = 8,
  parameter logic [RATIO-1:0] ALIGN_PATTERN = RATIO'(8'h3C),
  parameter int SETTLE_WORDS = 2,
  parameter int LOCK_WORDS = 4
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic [NCH-1:0]                   DATA_EVEN,
  input  logic [NCH-1:0]                   DATA_ODD,
  input  logic                             ALIGN_EN,
  input  logic                             BITSLIP,
  output logic [NCH*RATIO-1:0]             DATA_OUT,
  output logic                             DATA_VALID,
  output logic                             ALIGNED,
  output logic                             ALIGN_FAIL,
  output logic [$clog2(2*RATIO+1)-1:0]     SLIP_COUNT
);

  localparam int PW = $clog2(RATIO/2);
  localparam int OW = $clog2(RATIO);
  localparam int SW = $clog2(2*RATIO+1);
  localparam int MW = $clog2(LOCK_WORDS+1);
  localparam int WW = $clog2(SETTLE_WORDS+2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_WAIT,
    S_CHECK,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t                state, state_n;
  logic [PW-1:0]         phase;
  logic [OW-1:0]         offset, offset_n;
  logic [SW-1:0]         slip_cnt, slip_cnt_n;
  logic [MW-1:0]         match_cnt, match_n;
  logic [WW-1:0]         wait_cnt, wait_n;
  logic [2*RATIO-1:0]    sreg [NCH];
  logic [NCH*RATIO-1:0]  window;
  logic [RATIO-1:0]      frame_word;
  logic                  capture;
  logic                  bitslip_q;
  logic                  align_en_q;
  logic                  slip_rise;
  logic                  do_slip;
  logic                  mismatch;

  assign capture    = (phase == PW'(RATIO/2-1));
  assign slip_rise  = BITSLIP & ~bitslip_q;
  assign frame_word = window[FRAME_LANE*RATIO +: RATIO];

  // Larger offsets reach further back in the shift register, i.e. older bits.
  always_comb begin
    window = '0;
    for (int c = 0; c < NCH; c++) begin
      window[c*RATIO +: RATIO] = sreg[c][offset +: RATIO];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase      <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        sreg[c] <= '0;
      end
    end else begin
      phase      <= capture ? '0 : phase + 1'b1;
      DATA_VALID <= capture;
      if (capture) begin
        DATA_OUT <= window;
      end
      for (int c = 0; c < NCH; c++) begin
        sreg[c] <= {sreg[c][2*RATIO-3:0], DATA_EVEN[c], DATA_ODD[c]};
      end
    end
  end

  // align_en_q resets high so a level held through reset is not taken as a new request.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      offset     <= '0;
      slip_cnt   <= '0;
      match_cnt  <= '0;
      wait_cnt   <= '0;
      bitslip_q  <= 1'b0;
      align_en_q <= 1'b1;
    end else begin
      state      <= state_n;
      offset     <= offset_n;
      slip_cnt   <= slip_cnt_n;
      match_cnt  <= match_n;
      wait_cnt   <= wait_n;
      bitslip_q  <= BITSLIP;
      align_en_q <= ALIGN_EN;
    end
  end

  always_comb begin
    state_n  = state;
    match_n  = match_cnt;
    wait_n   = wait_cnt;
    do_slip  = 1'b0;
    mismatch = 1'b0;
    case (state)
      S_IDLE: begin
        if (ALIGN_EN && !align_en_q) begin
          state_n = S_HUNT;
          match_n = '0;
        end else if (!ALIGN_EN && slip_rise) begin
          do_slip = 1'b1;
        end
      end
      S_HUNT: begin
        if (capture) begin
          if (frame_word == ALIGN_PATTERN) begin
            match_n = MW'(1);
            state_n = (LOCK_WORDS <= 1) ? S_LOCKED : S_CHECK;
          end else begin
            mismatch = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (capture) begin
          if (frame_word == ALIGN_PATTERN) begin
            if (int'(match_cnt) + 1 >= LOCK_WORDS) begin
              state_n = S_LOCKED;
            end else begin
              match_n = match_cnt + 1'b1;
            end
          end else begin
            mismatch = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (capture) begin
          if (wait_cnt <= WW'(1)) begin
            state_n = S_HUNT;
            wait_n  = '0;
          end else begin
            wait_n = wait_cnt - 1'b1;
          end
        end
      end
      default: ;
    endcase

    // The slip that exhausts two full rotations is still applied, then the hunt gives up.
    if (mismatch) begin
      do_slip = 1'b1;
      match_n = '0;
      wait_n  = WW'(SETTLE_WORDS);
      if (int'(slip_cnt) + 1 >= 2*RATIO) begin
        state_n = S_FAIL;
      end else if (SETTLE_WORDS == 0) begin
        state_n = S_HUNT;
      end else begin
        state_n = S_WAIT;
      end
    end

    if (state != S_IDLE && !ALIGN_EN) begin
      state_n = S_IDLE;
      do_slip = 1'b0;
    end

    offset_n   = offset;
    slip_cnt_n = (state == S_IDLE && state_n == S_HUNT) ? '0 : slip_cnt;
    if (do_slip) begin
      offset_n = (offset == OW'(RATIO-1)) ? '0 : offset + 1'b1;
      if (slip_cnt != SW'(2*RATIO)) begin
        slip_cnt_n = slip_cnt + 1'b1;
      end
    end
  end

  assign ALIGNED    = (state == S_LOCKED);
  assign ALIGN_FAIL = (state == S_FAIL);
  assign SLIP_COUNT = slip_cnt;

endmodule

// File: tb/tb_ewrapper_rx_deser_align.sv
// tb/tb_ewrapper_rx_deser_align.sv - directed/random bench for ewrapper_rx_deser_align
// Expected words come from a recorded bit history and the word-window rule, not the RTL structure.
module tb_ewrapper_rx_deser_align;

  localparam int NCH  = 9;
  localparam int R    = 8;
  localparam int HMAX = 4096;

  logic              CLK;
  logic              RESET_N;
  logic [NCH-1:0]    DATA_EVEN;
  logic [NCH-1:0]    DATA_ODD;
  logic              ALIGN_EN;
  logic              BITSLIP;
  logic [NCH*R-1:0]  DATA_OUT;
  logic              DATA_VALID;
  logic              ALIGNED;
  logic              ALIGN_FAIL;
  logic [4:0]        SLIP_COUNT;

  ewrapper_rx_deser_align dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .DATA_EVEN(DATA_EVEN),
    .DATA_ODD(DATA_ODD),
    .ALIGN_EN(ALIGN_EN),
    .BITSLIP(BITSLIP),
    .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID),
    .ALIGNED(ALIGNED),
    .ALIGN_FAIL(ALIGN_FAIL),
    .SLIP_COUNT(SLIP_COUNT)
  );

  int             tests_run = 0;
  int             tests_failed = 0;
  int             edge_cnt = 0;
  int             first_edge = 0;
  logic [NCH-1:0] ev_h [HMAX];
  logic [NCH-1:0] od_h [HMAX];
  logic [7:0]     pat0, patf;
  int             s0, sf, tgt, cur_off, nxt_off, chg_edge;
  logic           chk_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Record every sampled pair; the first edge with reset released starts a fresh stream.
  always @(posedge CLK) begin
    if (edge_cnt < HMAX) begin
      ev_h[edge_cnt] = DATA_EVEN;
      od_h[edge_cnt] = DATA_ODD;
    end
    if (!RESET_N) first_edge = edge_cnt + 1;
    edge_cnt = edge_cnt + 1;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic pbit(input logic [7:0] p, input int n);
    int m;
    m = ((n % 8) + 8) % 8;
    return p[7-m];
  endfunction

  // Word captured at edge e with offset o: the R bits ending o bits before the newest received bit.
  function automatic logic [71:0] model(input int e, input int o);
    logic [71:0] w;
    int k, ed;
    w = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < R; i++) begin
        k  = o + R - 1 - i;
        ed = e - 1 - k / 2;
        if (ed >= first_edge && ed < HMAX)
          w[c*R + R - 1 - i] = (k % 2 == 0) ? od_h[ed][c] : ev_h[ed][c];
      end
    end
    return w;
  endfunction

  task automatic drive();
    logic [NCH-1:0] ev, od;
    int n;
    ev = NCH'($urandom);
    od = NCH'($urandom);
    n  = 2 * (edge_cnt - first_edge);
    ev[0] = pbit(pat0, n + s0);
    od[0] = pbit(pat0, n + s0 + 1);
    ev[8] = pbit(patf, n + sf);
    od[8] = pbit(patf, n + sf + 1);
    DATA_EVEN = ev;
    DATA_ODD  = od;
  endtask

  task automatic step();
    int e, o;
    logic exp_v;
    @(negedge CLK);
    e = edge_cnt - 1;
    exp_v = (e >= first_edge) && (((e - first_edge) % 4) == 3);
    chk("valid_cadence", 72'(DATA_VALID), 72'(exp_v));
    if (exp_v && chk_data) begin
      o = (e > chg_edge) ? nxt_off : cur_off;
      chk("data_model", DATA_OUT, model(e, o));
    end
    drive();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"},  DATA_OUT, 72'(0));
    chk({tag, "_valid"}, 72'(DATA_VALID), 72'(0));
    chk({tag, "_align"}, 72'(ALIGNED), 72'(0));
    chk({tag, "_fail"},  72'(ALIGN_FAIL), 72'(0));
    chk({tag, "_slips"}, 72'(SLIP_COUNT), 72'(0));
  endtask

  task automatic slip_pulse();
    BITSLIP  = 1'b1;
    cur_off  = nxt_off;
    nxt_off  = (cur_off + 1) % R;
    chg_edge = edge_cnt;
    step();
    BITSLIP = 1'b0;
    step();
  endtask

  task automatic next_word();
    for (int i = 0; i < 8; i++) begin
      step();
      if (DATA_VALID === 1'b1 && edge_cnt - 1 > chg_edge) break;
    end
  endtask

  initial begin
    RESET_N = 1'b0; ALIGN_EN = 1'b0; BITSLIP = 1'b0;
    DATA_EVEN = '0; DATA_ODD = '0;
    pat0 = 8'hA5; patf = 8'h3C; s0 = 2; sf = 7;
    cur_off = 0; nxt_off = 0; chg_edge = -1; chk_data = 1'b1;

    repeat (4) begin
      step();
      chk_reset("reset");
    end
    RESET_N = 1'b1;
    repeat (8) step();
    chk("word_valid", 72'(DATA_VALID), 72'(1));
    chk("lane0_a5", 72'(DATA_OUT[7:0]), 72'(8'hA5));
    chk("frame_off0_87", 72'(DATA_OUT[71:64]), 72'(8'h87));

    slip_pulse();
    next_word();
    chk("slip1_d2", 72'(DATA_OUT[7:0]), 72'(8'hD2));
    chk("slip1_count", 72'(SLIP_COUNT), 72'(1));
    slip_pulse();
    next_word();
    chk("slip2_69", 72'(DATA_OUT[7:0]), 72'(8'h69));
    chk("slip2_count", 72'(SLIP_COUNT), 72'(2));

    RESET_N = 1'b0;
    step();
    chk_reset("reset2");
    step();
    RESET_N = 1'b1;
    cur_off = 0; nxt_off = 0; chg_edge = -1;
    repeat (4) step();
    ALIGN_EN = 1'b1;
    chk_data = 1'b0;
    for (int i = 0; i < 400 && ALIGNED !== 1'b1; i++) step();
    chk("lock1_aligned", 72'(ALIGNED), 72'(1));
    chk("lock1_slips", 72'(SLIP_COUNT), 72'(5));
    chk("lock1_frame", 72'(DATA_OUT[71:64]), 72'(8'h3C));
    cur_off = 5; nxt_off = 5; chk_data = 1'b1;
    BITSLIP = 1'b1;
    step();
    BITSLIP = 1'b0;
    repeat (12) step();
    chk("locked_ignore_slip", 72'(SLIP_COUNT), 72'(5));
    chk("locked_stays", 72'(ALIGNED), 72'(1));
    ALIGN_EN = 1'b0;
    step();
    chk("drop_aligned", 72'(ALIGNED), 72'(0));
    repeat (8) step();

    tgt = $urandom_range(0, 7);
    sf  = tgt + 2;
    repeat (8) step();
    ALIGN_EN = 1'b1;
    BITSLIP  = 1'b1;
    chk_data = 1'b0;
    for (int i = 0; i < 400 && ALIGNED !== 1'b1; i++) step();
    BITSLIP = 1'b0;
    chk("lock2_aligned", 72'(ALIGNED), 72'(1));
    chk("lock2_slips", 72'(SLIP_COUNT), 72'((tgt - 5 + R) % R));
    chk("lock2_frame", 72'(DATA_OUT[71:64]), 72'(8'h3C));
    cur_off = tgt; nxt_off = tgt; chk_data = 1'b1;
    repeat (12) step();

    ALIGN_EN = 1'b0;
    patf = 8'h00;
    repeat (8) step();
    ALIGN_EN = 1'b1;
    chk_data = 1'b0;
    for (int i = 0; i < 600 && ALIGN_FAIL !== 1'b1; i++) step();
    chk("fail_flag", 72'(ALIGN_FAIL), 72'(1));
    chk("fail_aligned", 72'(ALIGNED), 72'(0));
    chk("fail_slips", 72'(SLIP_COUNT), 72'(16));
    chk_data = 1'b1;
    repeat (12) step();
    ALIGN_EN = 1'b0;
    step();
    chk("fail_cleared", 72'(ALIGN_FAIL), 72'(0));
    slip_pulse();
    repeat (8) step();
    chk("slip_saturated", 72'(SLIP_COUNT), 72'(16));

    patf = 8'h3C;
    tgt  = (nxt_off + 1 + $urandom_range(0, 6)) % R;
    sf   = tgt + 2;
    repeat (8) step();
    ALIGN_EN = 1'b1;
    chk_data = 1'b0;
    for (int i = 0; i < 100 && SLIP_COUNT !== 5'd1; i++) step();
    chk("hunt_first_slip", 72'(SLIP_COUNT), 72'(1));
    RESET_N = 1'b0;
    #1;
    chk_reset("reset_wait");
    step();
    step();
    RESET_N = 1'b1;
    cur_off = 0; nxt_off = 0; chg_edge = -1; chk_data = 1'b1;
    repeat (30) step();
    chk("no_restart_slips", 72'(SLIP_COUNT), 72'(0));
    chk("no_restart_aligned", 72'(ALIGNED), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ewrapper_rx_deser_align.md
Name: ewrapper_rx_deser_align

Overview:
- Parametrised single-clock deserializer and word aligner for eLink receive lanes.
- Sits after the per-lane IDDR primitives in the fast link clock domain. Each cycle it takes one even/odd bit pair per channel.
- Assembles RATIO-bit words per channel and emits them with a valid strobe.
- Aligns the word boundary through a programmable bit offset, set either by manual BITSLIP pulses or by an automatic training-pattern hunt on a designated frame lane.

Parameters:
- NCH, 9, number of data channels (lanes), 1..16.
- RATIO, 8, bits per output word per channel; even, 4..16.
- FRAME_LANE, 8, channel index used for automatic alignment; 0..NCH-1.
- ALIGN_PATTERN, 8'h3C, RATIO-bit training word expected on FRAME_LANE. It must differ from all of its own non-trivial rotations.
- SETTLE_WORDS, 2, words ignored after each slip before comparing again.
- LOCK_WORDS, 4, consecutive matching words required to declare lock.

Ports:
- CLK  in  1  fast link clock, rising edge only.
- RESET_N  in  1  asynchronous active-low reset.
- DATA_EVEN  in  NCH  first-in-time bit of the pair, per channel.
- DATA_ODD  in  NCH  second-in-time bit of the pair, per channel.
- ALIGN_EN  in  1  level: 1 = automatic alignment, 0 = manual mode.
- BITSLIP  in  1  manual slip request; acts on its rising edge, ignored while ALIGN_EN=1.
- DATA_OUT  out  NCH*RATIO  channel c occupies [c*RATIO+RATIO-1 : c*RATIO]; MSB is the oldest bit.
- DATA_VALID  out  1  one-cycle strobe when DATA_OUT updates.
- ALIGNED  out  1  automatic alignment locked.
- ALIGN_FAIL  out  1  sticky hunt failure.
- SLIP_COUNT  out  clog2(2*RATIO+1)  slips applied since the last hunt start or reset.

Behaviour:
- Reset (RESET_N=0, asynchronous, any state):
  - DATA_OUT=0, DATA_VALID=0, ALIGNED=0, ALIGN_FAIL=0, SLIP_COUNT=0.
  - offset=0, phase=0, shift registers=0, BITSLIP edge detector=0, state=IDLE.
  - Release is synchronous to the next CLK edge.
- Shift register, per channel:
  - 2*RATIO bits, newest bit at index 0.
  - Each edge shifts left by 2 and inserts {EVEN, ODD}, with ODD at index 0.
- Phase counter: free-running 0..RATIO/2-1, wrapping.
- Capture: on the edge where phase==RATIO/2-1, DATA_OUT[c] <= sreg_c[offset+RATIO-1 : offset] and DATA_VALID <= 1. On all other edges DATA_VALID <= 0.
  - Result: exactly one valid every RATIO/2 cycles.
- Latency at offset=0: the last pair of a word is presented in cycle t; DATA_VALID is high in cycle t+2.
- Offset:
  - Range 0..RATIO-1; each slip sets offset <= (offset+1) mod RATIO.
  - One slip moves the window one bit older. A repeating word therefore appears rotated right by 1.
  - The slip takes effect from the next capture. A slip coinciding with a capture edge uses the old offset for that capture.
- SLIP_COUNT:
  - Counts every applied slip, manual or automatic, saturating at 2*RATIO.
  - Cleared on entry to HUNT.
- State machine:
  - IDLE (ALIGN_EN=0): each BITSLIP rising edge applies one slip. ALIGN_EN 0->1 goes to HUNT.
  - HUNT: at each capture, compare the frame-lane word with ALIGN_PATTERN.
    - Match: match_cnt=1 and go to CHECK.
    - Mismatch: slip, wait_cnt=SETTLE_WORDS, go to WAIT.
    - If the slip would make the hunt's SLIP_COUNT reach 2*RATIO, go to FAIL instead.
  - WAIT: decrement wait_cnt on each capture; at 0 return to HUNT. The compare is skipped on those captures.
  - CHECK: at each capture:
    - Match: match_cnt++. Reaching LOCK_WORDS goes to LOCKED with ALIGNED<=1.
    - Mismatch: match_cnt=0, slip, go to WAIT. The failure check is the same as in HUNT.
  - LOCKED: no slips and no compares; the offset is frozen.
  - FAIL: ALIGN_FAIL=1; the offset is frozen.
  - From any non-IDLE state, ALIGN_EN=0 returns to IDLE on the next edge:
    - ALIGNED<=0 and ALIGN_FAIL<=0.
    - The offset is retained.
- BITSLIP is ignored in every state except IDLE. A rising edge that coincides with ALIGN_EN 0->1 is dropped.
- Reset asserted mid-hunt: the hunt aborts immediately and all outputs return to their reset values. After release, auto alignment restarts only once ALIGN_EN is seen rising.

Test Plan:
1. Reset and cadence: RESET_N=0 with random inputs -> all outputs 0. After release, NCH=9/RATIO=8 -> DATA_VALID pulses every 4 cycles, first on the 4th edge.
2. Manual framing at offset 0: lane0 pairs (1,0),(1,0),(0,1),(0,1) in phase 0..3 -> DATA_OUT[7:0]=8'hA5 with DATA_VALID 2 cycles after the last pair.
3. Manual slip: repeating 8'hA5 on lane0 plus one BITSLIP pulse -> following words 8'hD2, SLIP_COUNT=1. A second pulse -> 8'h69, SLIP_COUNT=2.
4. Auto lock: frame lane 8 streams 0x3C, which appears as 0x87 at offset 0; ALIGN_EN 0->1 -> 5 slips, DATA_OUT[71:64]=8'h3C, SLIP_COUNT=5, ALIGNED=1 after 4 matching words, no further slips.
5. Failure: frame lane constant 8'h00 with ALIGN_EN=1 -> ALIGN_FAIL=1 after 16 slips, ALIGNED=0. Dropping ALIGN_EN -> ALIGN_FAIL=0 next edge.
6. Disturbances:
   - RESET_N pulsed while in WAIT -> outputs at reset values.
   - ALIGN_EN dropped while LOCKED -> ALIGNED=0, offset kept.
   - A BITSLIP pulse while ALIGN_EN=1 -> offset unchanged.
